register_capture: RTL

REGISTER_CAPTURE -- requirements
Module: register_capture

---
 rtl/register_capture.sv | 116 +++++++++++
 1 files changed

// File: rtl/register_capture.sv
// Purpose : CPU-style register file capture stage: X/Y/AC/S, PC with increment, ABL/ABH, DOR, DL.
// Latency : one cycle; every register output reflects its strobe on the next rising i_clk edge.
// Backpr. : none; strobes are accepted every cycle and nothing can stall the block.
//
// Ports:
//   i_clk, i_reset_n                 clock and asynchronous active-low reset
//   i_bus_db/sb/adl/adh, i_data      internal bus values and external data bus (8 bits each)
//   i_sb_x/y/ac/s                    load X/Y/AC/S from SB
//   i_adl_abl, i_adh_abh             load ABL from ADL, ABH from ADH
//   i_adl_pcl, i_pcl_pcl             PCL source select (ADL has priority)
//   i_adh_pch, i_pch_pch             PCH source select (ADH has priority)
//   i_i_pc                           increment PC (carry from PCL into PCH)
//   i_db_dor, i_rw                   load DOR from DB; read cycle loads DL from i_data
//   o_x ... o_dl, o_address          registered values, o_address = {ABH, ABL}
//   o_conflict                       only with BUS_CONFLICT_CHECK_EN: sticky flag set when
//                                    both PCL strobes or both PCH strobes are high together
module register_capture (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [7:0]  i_bus_db,
  input  logic [7:0]  i_bus_sb,
  input  logic [7:0]  i_bus_adl,
  input  logic [7:0]  i_bus_adh,
  input  logic [7:0]  i_data,
  input  logic        i_sb_x,
  input  logic        i_sb_y,
  input  logic        i_sb_ac,
  input  logic        i_sb_s,
  input  logic        i_adl_abl,
  input  logic        i_adh_abh,
  input  logic        i_adl_pcl,
  input  logic        i_pcl_pcl,
  input  logic        i_adh_pch,
  input  logic        i_pch_pch,
  input  logic        i_i_pc,
  input  logic        i_db_dor,
  input  logic        i_rw,
  output logic [7:0]  o_x,
  output logic [7:0]  o_y,
  output logic [7:0]  o_ac,
  output logic [7:0]  o_s,
  output logic [7:0]  o_pcl,
  output logic [7:0]  o_pch,
  output logic [7:0]  o_abl,
  output logic [7:0]  o_abh,
  output logic [7:0]  o_dor,
  output logic [7:0]  o_dl,
  output logic [15:0] o_address
`ifdef BUS_CONFLICT_CHECK_EN
  ,
  output logic        o_conflict
`endif
);

  logic [7:0] pcl_src;
  logic [7:0] pch_src;
  logic       pcl_carry;
  logic [7:0] pcl_nxt;
  logic [7:0] pch_nxt;
  logic       pcl_en;
  logic       pch_en;

  // Source select: ADL/ADH wins over the self-path; the self-path and "no
  // strobe" both yield the current value, so the increment still applies.
  always_comb begin
    pcl_src   = o_pcl;
    pch_src   = o_pch;
    if (i_adl_pcl) pcl_src = i_bus_adl;
    if (i_adh_pch) pch_src = i_bus_adh;
    pcl_carry = i_i_pc & (pcl_src == 8'hFF);
    pcl_nxt   = pcl_src + {7'd0, i_i_pc};
    pch_nxt   = pch_src + {7'd0, pcl_carry};
    pcl_en    = i_adl_pcl | i_pcl_pcl | i_i_pc;
    pch_en    = i_adh_pch | i_pch_pch | pcl_carry;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_x   <= 8'h00;
      o_y   <= 8'h00;
      o_ac  <= 8'h00;
      o_s   <= 8'h00;
      o_pcl <= 8'h00;
      o_pch <= 8'h00;
      o_abl <= 8'h00;
      o_abh <= 8'h00;
      o_dor <= 8'h00;
      o_dl  <= 8'h00;
    end else begin
      if (i_sb_x)    o_x   <= i_bus_sb;
      if (i_sb_y)    o_y   <= i_bus_sb;
      if (i_sb_ac)   o_ac  <= i_bus_sb;
      if (i_sb_s)    o_s   <= i_bus_sb;
      if (pcl_en)    o_pcl <= pcl_nxt;
      if (pch_en)    o_pch <= pch_nxt;
      if (i_adl_abl) o_abl <= i_bus_adl;
      if (i_adh_abh) o_abh <= i_bus_adh;
      if (i_db_dor)  o_dor <= i_bus_db;
      if (i_rw)      o_dl  <= i_data;
    end
  end

  assign o_address = {o_abh, o_abl};

`ifdef BUS_CONFLICT_CHECK_EN
  logic conflict_hit;
  assign conflict_hit = (i_adl_pcl & i_pcl_pcl) | (i_adh_pch & i_pch_pch);

  // Sticky: only reset clears it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)        o_conflict <= 1'b0;
    else if (conflict_hit) o_conflict <= 1'b1;
  end
`endif

endmodule
